// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared definitions for the run controller.
//   - OP_* : command opcodes carried on i_cmd_op
//   - state_t : controller state encoding, also exported on o_state
package run_ctrl_pkg;

    localparam logic [2:0] OP_RUN     = 3'b000;
    localparam logic [2:0] OP_STEP    = 3'b001;
    localparam logic [2:0] OP_RUN_N   = 3'b010;
    localparam logic [2:0] OP_STOP    = 3'b011;
    localparam logic [2:0] OP_RESTART = 3'b100;

    typedef enum logic [2:0] {
        PRST   = 3'd0,
        IDLE   = 3'd1,
        RUN    = 3'd2,
        RUNN   = 3'd3,
        STEP   = 3'd4,
        HALTED = 3'd5
    } state_t;

    // States in which the processor clock enable is high.
    function automatic logic is_run_state(input state_t s);
        return (s == RUN) || (s == RUNN) || (s == STEP);
    endfunction

endpackage

// File: rtl/run_cnt.sv
// run_cnt: loadable down-counter with zero flag.
//   clk, reset  : clock, asynchronous active-low reset (count <= RST_VAL)
//   load        : load load_val (has priority over dec)
//   load_val    : value to load
//   dec         : decrement by one; holds at zero
//   zero        : count is zero
module run_cnt #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: command-driven run controller for the processor top.
// Sequences the processor reset, gates the processor clock enable for
// free runs, single steps and N-cycle runs, and stops on a retired HALT.
//   clk, reset   : clock, asynchronous active-low controller reset
//   i_cmd_valid  : command valid
//   o_cmd_ready  : command can be accepted this cycle
//   i_cmd_op     : opcode (OP_* in run_ctrl_pkg; unknown ops are ignored)
//   i_cmd_arg    : cycle budget for RUN_N
//   i_halt       : processor retired HALT (looked at only while enabled)
//   o_cpu_rst    : synchronous reset to the processor top
//   o_cpu_en     : processor clock enable
//   o_cycle_cnt  : enabled cycles since last processor reset, saturating
//   o_state      : current controller state
//   o_done       : one-cycle pulse when a run ends
//   o_halted     : HALT seen
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high; at most one command per cycle. All outputs
// are registered, computed from the next state.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int RST_STRETCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [CNT_W-1:0] i_cmd_arg,
    input  logic             i_halt,
    output logic             o_cpu_rst,
    output logic             o_cpu_en,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [2:0]       o_state,
    output logic             o_done,
    output logic             o_halted
);

    localparam int STR_W = $clog2(RST_STRETCH + 1);

    state_t state_q, state_d;
    logic   done_d;
    logic   accept, halt_hit;
    logic   bud_load, bud_dec, bud_zero;
    logic   str_load, str_dec, str_zero;

    assign accept   = i_cmd_valid & o_cmd_ready;
    assign halt_hit = o_cpu_en & i_halt;

    // The budget is loaded with arg-1 so that the zero flag is seen during
    // the last enabled cycle, letting the run end on that edge.
    run_cnt #(.W(CNT_W), .RST_VAL('0)) u_budget (
        .clk      (clk),
        .reset    (reset),
        .load     (bud_load),
        .load_val (i_cmd_arg - CNT_W'(1)),
        .dec      (bud_dec),
        .zero     (bud_zero)
    );

    // After controller reset the first edge already counts toward the
    // stretch, so the reset value is RST_STRETCH; a RESTART is accepted on
    // an edge of its own, so it loads RST_STRETCH-1. Both give RST_STRETCH
    // cycles of o_cpu_rst after the triggering edge.
    run_cnt #(.W(STR_W), .RST_VAL(STR_W'(RST_STRETCH))) u_stretch (
        .clk      (clk),
        .reset    (reset),
        .load     (str_load),
        .load_val (STR_W'(RST_STRETCH - 1)),
        .dec      (str_dec),
        .zero     (str_zero)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        bud_load = 1'b0;
        bud_dec  = 1'b0;
        str_load = 1'b0;
        str_dec  = 1'b0;
        case (state_q)
            PRST: begin
                if (str_zero) state_d = IDLE;
                else          str_dec = 1'b1;
            end
            IDLE: begin
                if (accept) begin
                    case (i_cmd_op)
                        OP_RUN:  state_d = RUN;
                        OP_STEP: state_d = STEP;
                        OP_RUN_N: begin
                            if (i_cmd_arg != '0) begin
                                state_d  = RUNN;
                                bud_load = 1'b1;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        OP_RESTART: begin
                            state_d  = PRST;
                            str_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN, RUNN: begin
                // HALT wins over every other way of ending the run.
                if (halt_hit) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else if (accept && (i_cmd_op == OP_RESTART)) begin
                    state_d  = PRST;
                    str_load = 1'b1;
                end else if (accept && (i_cmd_op == OP_STOP)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (state_q == RUNN) begin
                    if (bud_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bud_dec = 1'b1;
                    end
                end
            end
            STEP: begin
                state_d = halt_hit ? HALTED : IDLE;
                done_d  = 1'b1;
            end
            HALTED: begin
                if (accept && (i_cmd_op == OP_RESTART)) begin
                    state_d  = PRST;
                    str_load = 1'b1;
                end
            end
            default: begin
                state_d  = PRST;
                str_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PRST;
            o_cpu_rst   <= 1'b1;
            o_cpu_en    <= 1'b0;
            o_cmd_ready <= 1'b0;
            o_done      <= 1'b0;
            o_halted    <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            state_q     <= state_d;
            o_cpu_rst   <= (state_d == PRST);
            o_cpu_en    <= is_run_state(state_d);
            o_cmd_ready <= (state_d == IDLE) || (state_d == RUN) ||
                           (state_d == RUNN) || (state_d == HALTED);
            o_done      <= done_d;
            o_halted    <= (state_d == HALTED);
            if (state_d == PRST) begin
                o_cycle_cnt <= '0;
            end else if (o_cpu_en && (o_cycle_cnt != '1)) begin
                o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: bench for run_ctrl. Two instances (32-bit and 4-bit cycle
// counter) share all stimulus; a behavioural model tracks remaining reset
// cycles, remaining run cycles and the enabled-cycle count.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int RST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cmd_valid;
    logic [2:0]  i_cmd_op;
    logic [31:0] i_cmd_arg;
    logic        i_halt;

    logic        rdy32, rst32, en32, done32, hlt32;
    logic [31:0] cnt32;
    logic [2:0]  st32;
    logic        rdy4, rst4, en4, done4, hlt4;
    logic [3:0]  cnt4;
    logic [2:0]  st4;

    always #5 clk = ~clk;

    run_ctrl #(.CNT_W(32), .RST_STRETCH(RST)) dut32 (
        .clk(clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(rdy32),
        .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg), .i_halt(i_halt),
        .o_cpu_rst(rst32), .o_cpu_en(en32), .o_cycle_cnt(cnt32), .o_state(st32),
        .o_done(done32), .o_halted(hlt32)
    );

    run_ctrl #(.CNT_W(4), .RST_STRETCH(RST)) dut4 (
        .clk(clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(rdy4),
        .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg[3:0]), .i_halt(i_halt),
        .o_cpu_rst(rst4), .o_cpu_en(en4), .o_cycle_cnt(cnt4), .o_state(st4),
        .o_done(done4), .o_halted(hlt4)
    );

    // ---------------- behavioural model ----------------
    int     rst_left;   // processor-reset cycles still to show
    int     run_left;   // -1 free run, 0 not running, >0 enabled cycles left
    bit     stepping;
    bit     m_halted;
    longint m_cnt;
    bit     m_done;

    int vectors = 0;
    int fails   = 0;
    int seg_en, seg_done, seg_rst;

    function automatic bit m_en();
        return (rst_left == 0) && !m_halted && (run_left != 0);
    endfunction

    function automatic bit m_ready();
        return (rst_left == 0) && !stepping;
    endfunction

    function automatic logic [2:0] m_state();
        if (rst_left > 0)   return PRST;
        if (m_halted)       return HALTED;
        if (stepping)       return STEP;
        if (run_left == -1) return RUN;
        if (run_left > 0)   return RUNN;
        return IDLE;
    endfunction

    task automatic model_reset();
        rst_left = RST + 1;
        run_left = 0;
        stepping = 0;
        m_halted = 0;
        m_cnt    = 0;
        m_done   = 0;
    endtask

    task automatic model_restart();
        rst_left = RST;
        run_left = 0;
        stepping = 0;
        m_halted = 0;
        m_cnt    = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit v, input logic [2:0] op, input int arg, input bit h);
        bit acc;
        if (!reset) begin
            model_reset();
            return;
        end
        acc    = v && m_ready();
        m_done = 0;
        if (rst_left > 0) begin
            rst_left--;
        end else if (m_en()) begin
            m_cnt++;
            if (h) begin
                m_halted = 1; run_left = 0; stepping = 0; m_done = 1;
            end else if (acc && op == OP_RESTART) begin
                model_restart();
            end else if (acc && op == OP_STOP) begin
                run_left = 0; m_done = 1;
            end else if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    m_done = 1; stepping = 0;
                end
            end
        end else if (m_halted) begin
            if (acc && op == OP_RESTART) model_restart();
        end else if (acc) begin
            case (op)
                OP_RUN:     run_left = -1;
                OP_STEP:    begin run_left = 1; stepping = 1; end
                OP_RUN_N:   if (arg == 0) m_done = 1; else run_left = arg;
                OP_RESTART: model_restart();
                default: ;
            endcase
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        longint sat4;
        sat4 = (m_cnt > 15) ? 15 : m_cnt;
        vectors++;
        chk("state32",  64'(st32),   64'(m_state()));
        chk("cpu_rst32", 64'(rst32), 64'(rst_left > 0));
        chk("cpu_en32", 64'(en32),   64'(m_en()));
        chk("ready32",  64'(rdy32),  64'(m_ready()));
        chk("done32",   64'(done32), 64'(m_done));
        chk("halted32", 64'(hlt32),  64'(m_halted));
        chk("cnt32",    64'(cnt32),  64'(m_cnt));
        chk("state4",   64'(st4),    64'(m_state()));
        chk("cpu_rst4", 64'(rst4),   64'(rst_left > 0));
        chk("cpu_en4",  64'(en4),    64'(m_en()));
        chk("ready4",   64'(rdy4),   64'(m_ready()));
        chk("done4",    64'(done4),  64'(m_done));
        chk("halted4",  64'(hlt4),   64'(m_halted));
        chk("cnt4",     64'(cnt4),   64'(sat4));
        seg_en   += int'(en32);
        seg_done += int'(done32);
        seg_rst  += int'(rst32);
    endtask

    // ---------------- driver ----------------
    task automatic seg_clear();
        seg_en = 0; seg_done = 0; seg_rst = 0;
    endtask

    task automatic cycle(input bit v, input logic [2:0] op, input int arg, input bit h);
        i_cmd_valid = v;
        i_cmd_op    = op;
        i_cmd_arg   = 32'(arg);
        i_halt      = h;
        model_step(v, op, arg, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, OP_STOP, 0, 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !rdy32; i++) idle(1);
        chk("ready_timeout", 64'(rdy32), 64'd1);
    endtask

    task automatic restart();
        cycle(1, OP_RESTART, 0, 0);
        wait_ready();
    endtask

    initial begin
        int n;
        reset = 1'b0;
        i_cmd_valid = 0; i_cmd_op = '0; i_cmd_arg = '0; i_halt = 0;
        model_reset();
        seg_clear();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        chk("reset_cpu_rst", 64'(rst32), 64'd1);
        chk("reset_ready",   64'(rdy32), 64'd0);
        chk("reset_state",   64'(st32),  64'(PRST));

        // Release, stretch, then RUN_N 10.
        reset = 1'b1;
        seg_clear();
        wait_ready();
        chk("stretch_len", 64'(seg_rst), 64'd4);
        seg_clear();
        cycle(1, OP_RUN_N, 10, 0);
        idle(12);
        chk("runn10_en",   64'(seg_en),   64'd10);
        chk("runn10_done", 64'(seg_done), 64'd1);
        chk("runn10_cnt",  64'(cnt32),    64'd10);

        // Three back-to-back STEPs.
        restart();
        chk("restart_cnt", 64'(cnt32), 64'd0);
        seg_clear();
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (rdy32) n++;
            cycle(1, OP_STEP, 0, 0);
        end
        idle(3);
        chk("step_en",   64'(seg_en),   64'd3);
        chk("step_done", 64'(seg_done), 64'd3);
        chk("step_cnt",  64'(cnt32),    64'd3);

        // RUN, STOP after 7 enabled cycles, then RUN_N 0.
        restart();
        seg_clear();
        cycle(1, OP_RUN, 0, 0);
        idle(6);
        cycle(1, OP_STOP, 0, 0);
        idle(1);
        chk("stop_en",   64'(seg_en),   64'd7);
        chk("stop_done", 64'(seg_done), 64'd1);
        chk("stop_cnt",  64'(cnt32),    64'd7);
        seg_clear();
        cycle(1, OP_RUN_N, 0, 0);
        idle(2);
        chk("runn0_en",   64'(seg_en),   64'd0);
        chk("runn0_done", 64'(seg_done), 64'd1);

        // RUN_N 5 with HALT on the 5th enabled cycle.
        restart();
        seg_clear();
        cycle(1, OP_RUN_N, 5, 0);
        idle(4);
        cycle(0, OP_STOP, 0, 1);
        idle(2);
        chk("halt_state",  64'(st32),     64'(HALTED));
        chk("halt_flag",   64'(hlt32),    64'd1);
        chk("halt_done",   64'(seg_done), 64'd1);
        chk("halt_cnt",    64'(cnt32),    64'd5);
        cycle(1, OP_STEP, 0, 0);
        idle(2);
        chk("halt_step_ignored", 64'(st32), 64'(HALTED));
        chk("halt_step_en",      64'(seg_en), 64'd5);
        restart();
        chk("restart_halted", 64'(hlt32), 64'd0);
        chk("restart_cnt2",   64'(cnt32), 64'd0);

        // Saturation of the 4-bit counter.
        cycle(1, OP_RUN, 0, 0);
        idle(19);
        cycle(1, OP_STOP, 0, 0);
        idle(1);
        chk("sat_cnt4",  64'(cnt4),  64'd15);
        chk("sat_cnt32", 64'(cnt32), 64'd20);

        // Asynchronous reset between edges during a run.
        restart();
        cycle(1, OP_RUN, 0, 0);
        idle(3);
        #2 reset = 1'b0;
        #1;
        chk("async_cpu_rst", 64'(rst32), 64'd1);
        chk("async_en",      64'(en32),  64'd0);
        chk("async_cnt",     64'(cnt32), 64'd0);
        chk("async_cnt4",    64'(cnt4),  64'd0);
        chk("async_state",   64'(st32),  64'(PRST));
        chk("async_ready",   64'(rdy32), 64'd0);
        model_reset();
        idle(1);
        reset = 1'b1;
        seg_clear();
        wait_ready();
        chk("async_stretch", 64'(seg_rst), 64'd4);

        // Randomised phase.
        for (int i = 0; i < 2000; i++) begin
            bit         v, h;
            logic [2:0] op;
            int         arg;
            v   = ($urandom_range(0, 3) == 0);
            op  = 3'($urandom_range(0, 7));
            if (op == OP_RESTART && $urandom_range(0, 9) != 0) op = OP_RUN;
            arg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            h   = ($urandom_range(0, 31) == 0);
            if (v && op == OP_RESTART) h = 0;
            cycle(v, op, arg, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller between the debug/host interface and the pipelined processor top. It sequences the processor reset, gates the processor clock enable for continuous, single-step or N-cycle runs, and stops on a retired HALT instruction. It replaces fixed-delay reset and run sequencing with a command-driven controller that counts cycles, so bench and board share one controller.

## Interface
- CNT_W, 32, width of cycle budget and cycle counter
- RST_STRETCH, 4, cycles the processor is held in reset after controller reset release or RESTART (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low controller reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command can be accepted this cycle
- i_cmd_op  in  3  000 RUN, 001 STEP, 010 RUN_N, 011 STOP, 100 RESTART; others are accepted and ignored
- i_cmd_arg  in  CNT_W  cycle budget for RUN_N
- i_halt  in  1  processor retired HALT this cycle
- o_cpu_rst  out  1  active-high synchronous reset to processor top
- o_cpu_en  out  1  processor clock enable, registered
- o_cycle_cnt  out  CNT_W  enabled cycles since last processor reset, saturating
- o_state  out  3  current FSM state
- o_done  out  1  one-cycle pulse when a run ends
- o_halted  out  1  HALT seen, level

## Operation
- Reset values while reset=0: state PRST, o_cpu_rst=1, o_cpu_en=0, o_cycle_cnt=0, o_done=0, o_halted=0, o_cmd_ready=0.
- States:
  - PRST: hold o_cpu_rst=1 for RST_STRETCH cycles, clear o_cycle_cnt and o_halted, then go to IDLE.
  - IDLE: ready=1.
    - RUN goes to RUN.
    - STEP goes to STEP.
    - RUN_N with arg>0 loads the budget and goes to RUNN. RUN_N with arg=0 pulses o_done and stays in IDLE.
    - STOP is a no-op.
    - RESTART goes to PRST.
  - RUN: en=1 every cycle; ready=1. STOP goes to IDLE with a done pulse. RESTART goes to PRST without a done pulse. Other ops are ignored.
  - RUNN: like RUN, and the budget decrements on each enabled cycle. When the budget reaches 0 the state goes to IDLE with a done pulse.
  - STEP: exactly one enabled cycle, then IDLE with a done pulse. ready=0.
  - HALTED: en=0, o_halted=1, ready=1. Only RESTART acts. Other ops are ignored.
- Handshake: a command is accepted on an edge with i_cmd_valid & o_cmd_ready. One command per cycle.
- i_halt is sampled only on edges where o_cpu_en=1.
  - HALT goes to HALTED with a done pulse, from any run state.
  - HALT overrides STOP, budget expiry and step end in the same cycle. Exactly one done pulse is produced.
- o_cycle_cnt increments on each edge with o_cpu_en=1 and saturates at all-ones.
- Budget arithmetic is unsigned CNT_W. There is no wrap.

## Timing
- Command accepted at edge k: o_cpu_en is high from cycle k+1.
  - RUN_N N: en is high for exactly N cycles, k+1..k+N. o_done is high in cycle k+N+1, with state IDLE and ready=1 in that cycle.
  - STEP: en is high in cycle k+1 only. o_done is high in cycle k+2.
  - STOP accepted at edge j during a run: en is low from cycle j+1. o_done is high in cycle j+1.
- i_halt high in enabled cycle h: en is low from h+1, o_halted=1 from h+1, and o_done is high in h+1. Cycle h is counted.
- Controller reset release: o_cpu_rst stays high for RST_STRETCH cycles after the first clk edge with reset=1. ready rises in the cycle o_cpu_rst falls.
- RESTART accepted at edge k: o_cpu_rst=1 and en=0 from k+1 for RST_STRETCH cycles.
- Asynchronous reset assertion mid-run forces the reset values immediately, without waiting for a clock edge.

## Structure
- Package run_ctrl_pkg holds the opcode constants (OP_RUN, OP_STEP, OP_RUN_N, OP_STOP, OP_RESTART) and the state encoding (PRST, IDLE, RUN, RUNN, STEP, HALTED).
- Sub-module run_cnt is a parametrised loadable down-counter with a zero flag. It is used for both the budget and the reset stretch.
- The outputs are registered.
- The existing processor top is instantiated beside run_ctrl, never inside it.

## Test plan
- Reset release, then RUN_N arg=10 → o_cpu_rst high for 4 cycles; en high for exactly 10 cycles; o_done pulse once; o_cycle_cnt=10.
- STEP issued three times back-to-back as soon as ready rises → three separate single en cycles; o_cycle_cnt=3; three done pulses.
- RUN, then STOP after 7 enabled cycles → en low on the next cycle; done pulse; o_cycle_cnt=7. A following RUN_N 0 → immediate done, no en cycle.
- RUN_N 5 with i_halt asserted on the 5th enabled cycle → state HALTED, o_halted=1, a single done pulse, o_cycle_cnt=5. STEP is then ignored. RESTART clears o_halted and o_cycle_cnt after the 4-cycle stretch.
- CNT_W=4, RUN for 20 cycles → o_cycle_cnt saturates at 15.
- reset driven low mid-RUN between clock edges → o_cpu_rst=1, en=0, o_cycle_cnt=0 immediately. The normal stretch applies after release.
